sm_muldiv: RTL
==============

# sm_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the schoolMIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and serves MFHI/MFLO reads. It sits beside `sm_alu` in `sm_cpu`, and the control unit stalls the PC while `busy` is high. It uses a radix-2, one-bit-per-cycle datapath parametrised in operand width.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; must be ≥ 4 and even.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcA`  in  WIDTH  multiplicand or dividend.
- `srcB`  in  WIDTH  multiplier or divisor.
- `cancel`  in  1  abort a running operation.
- `hiWe`, `loWe`  in  1 each  MTHI/MTLO write strobes.
- `wData`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse; new HI/LO are valid.
- `divZero`  out  1  last DIV/DIVU had divisor 0.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO.

## Operation
- States:
  - IDLE: `start` → LOAD. Operands are captured on the same edge.
  - CALC: `WIDTH` iterations, counted by a `$clog2(WIDTH)+1`-bit counter; at count `WIDTH-1` → FIX.
  - FIX: sign correction and HI/LO write; → IDLE.
  - LOAD is folded into the IDLE→CALC edge, so there are three encoded states: IDLE, CALC, FIX.
- Operand capture:
  - Signed ops (MULT, DIV) take the absolute values of `srcA`/`srcB` and record the result signs.
  - For multiply, the product sign is the XOR of the operand signs.
  - For divide, the quotient sign is the XOR of the operand signs; the remainder sign is the sign of `srcA`.
- Multiply: shift-add into a 2·WIDTH accumulator. Result: HI = upper half, LO = lower half.
- Divide: restoring division, WIDTH+1-bit partial remainder. Result: LO = quotient, HI = remainder.
  - Quotient is truncated toward zero.
  - Most-negative / −1 yields LO = 1 followed by WIDTH−1 zeros, HI = 0, with no error flag.
- Divisor 0 (DIV or DIVU):
  - Normal timing; `divZero` = 1.
  - HI = `srcA` as given (unsigned), LO = all ones.
  - `divZero` holds until the next accepted `start`.
- `start` while busy: ignored.
- `cancel` in CALC or FIX: → IDLE on that edge. HI/LO are unchanged, no `done` pulse, `divZero` is unchanged. `cancel` in IDLE has no effect.
- `hiWe`/`loWe` write `wData` in IDLE only; they are ignored while busy.
  - If `start` and a write strobe occur in the same IDLE cycle, `start` wins and the write is dropped.
- `hi`/`lo` are driven directly from registers and are readable in every state; they show old values while busy.

## Timing
- Reset values: state IDLE; `busy` = 0, `done` = 0, `divZero` = 0, `hi` = 0, `lo` = 0, counter = 0.
- Reset mid-operation discards the operation immediately (asynchronous).
- `start` sampled at edge E0:
  - `busy` = 1 from E0 through E0+WIDTH+1, i.e. WIDTH+1 cycles.
  - After edge E0+WIDTH+1: new HI/LO are visible, `done` = 1 for one cycle, `busy` = 0.
- In the `done` cycle the unit is IDLE, so a back-to-back `start` is accepted in that cycle.
- MTHI/MTLO latency: one edge.
- `divZero` updates on the FIX edge, together with `done`.

## Structure
- `sm_cpu.vh` holds:
  - the `MD_MULT`/`MD_MULTU`/`MD_DIV`/`MD_DIVU` op codes;
  - the `MD_IDLE`/`MD_CALC`/`MD_FIX` state codes;
  - the control-unit function codes for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Sub-module `sm_muldiv_step` is a combinational single-iteration datapath, parametrised by `WIDTH`.
  - It takes the accumulator/remainder, operand and mode.
  - It returns the next accumulator/remainder.
  - FSM, counter, sign logic and HI/LO registers stay in `sm_muldiv`.

## Test plan
All scenarios use `WIDTH` = 32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `busy` is high exactly 33 cycles; `done` pulses once, after the 33rd edge.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7 / 2 → LO = 3, HI = 1.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0, `divZero` = 0.
- DIVU 5 / 0 → HI = 5, LO = 0xFFFFFFFF, `divZero` = 1. `divZero` stays 1 until the next `start`, then clears.
- MTHI 0x1234 in IDLE → `hi` = 0x1234 next cycle.
- MULT, then `cancel` at cycle 10 → no `done`, HI/LO unchanged.
- MULT, then `start`/`hiWe` pulsed mid-operation → both ignored.
- MULT, then `rst_n` low at cycle 20 → all outputs 0 immediately.

Source files
------------

// File: rtl/sm_muldiv_pkg.sv
// Shared codes for the schoolMIPS multiply/divide unit.
// Op select, FSM state encoding and control-unit function codes.
package sm_muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc = {partial product, multiplier} or {remainder, quotient}.
module sm_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_nxt = '0;
        if (div) begin
            // remainder stays below the divisor, so W bits suffice
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nxt = {sum, acc[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Magnitudes are iterated; signs are applied in the FIX state.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wData,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q, neg_lo_q, neg_hi_q, dz_q;
    logic               done_q, div_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               last;
    logic               sa, sb, dz;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc_q),
        .opnd    (opnd_q),
        .div     (div_q),
        .acc_nxt (acc_nxt)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        sa    = !op[0] && srcA[WIDTH-1];
        sb    = !op[0] && srcB[WIDTH-1];
        abs_a = sa ? -srcA : srcA;
        abs_b = sb ? -srcB : srcB;
        dz    = op[1] && (srcB == '0);
    end

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        q_fix    = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        r_fix    = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH]
                            : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= MD_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: if (start) state_d = MD_CALC;
            MD_CALC: begin
                if (cancel)    state_d = MD_IDLE;
                else if (last) state_d = MD_FIX;
            end
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != MD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            div_q      <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        cnt_q      <= '0;
                        div_q      <= op[1];
                        dz_q       <= dz;
                        div_zero_q <= 1'b0;
                        if (op[1]) begin
                            // zero divisor: keep raw srcA so HI returns it
                            acc_q    <= {{WIDTH{1'b0}}, dz ? srcA : abs_a};
                            opnd_q   <= abs_b;
                            neg_lo_q <= !dz && (sa ^ sb);
                            neg_hi_q <= !dz && sa;
                        end else begin
                            acc_q    <= {{WIDTH{1'b0}}, abs_b};
                            opnd_q   <= abs_a;
                            neg_lo_q <= sa ^ sb;
                            neg_hi_q <= 1'b0;
                        end
                    end else begin
                        if (hiWe) hi_q <= wData;
                        if (loWe) lo_q <= wData;
                    end
                end
                MD_CALC: begin
                    if (!cancel) begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MD_FIX: begin
                    if (!cancel) begin
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                        if (div_q) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done    = done_q;
    assign divZero = div_zero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
